// File: rtl/oam_dma.sv
`default_nettype none
// oam_dma: sprite DMA; a CPU write to $4014 copies page {data,$00..$FF} to $2004 while stalling the CPU.
// Build option OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state. Revision 1.0.
module oam_dma (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ce_in,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_r,
   input  logic        cpu_w,
   input  logic [7:0]  bus_i,
   output logic        cpu_ce,
   output logic [15:0] A,
   output logic [7:0]  D,
   output logic        R,
   output logic        W,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_RD    = 3'd3,
      S_WR    = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;

`ifdef OAM_DMA_ALIGN_EN
   logic       parity_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else if (ce_in) begin
         parity_q <= ~parity_q;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         page_q  <= 8'h00;
         cnt_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      if (ce_in) begin
         case (state_q)
            S_IDLE: begin
               if (cpu_w && (cpu_a == 16'h4014)) begin
                  page_d  = cpu_d;
                  cnt_d   = 8'h00;
                  state_d = S_HALT;
               end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
               // parity has already toggled once since the trigger edge, so 0 here means odd entry
               state_d = parity_q ? S_RD : S_ALIGN;
`else
               state_d = S_RD;
`endif
            end
            S_ALIGN: state_d = S_RD;
            S_RD: begin
               data_d  = bus_i;
               state_d = S_WR;
            end
            S_WR: begin
               if (cnt_q == 8'hFF) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_RD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Reset gates busy so the CPU sees passthrough for as long as reset_n is held low.
   assign busy   = reset_n && (state_q != S_IDLE);
   assign cpu_ce = ce_in && !busy;

   always_comb begin
      A = cpu_a;
      D = cpu_d;
      R = cpu_r;
      W = cpu_w;
      if (busy) begin
         D = data_q;
         R = 1'b0;
         W = 1'b0;
         case (state_q)
            S_RD: begin
               A = {page_q, cnt_q};
               R = 1'b1;
            end
            S_WR: begin
               A = 16'h2004;
               W = 1'b1;
            end
            default: A = {page_q, 8'h00};
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// tb_oam_dma: randomized scoreboard bench; expected bus cycles and busy lengths come from the DMA rules.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_in = 1'b0;
   logic [15:0] cpu_a = 16'h0000;
   logic [7:0]  cpu_d = 8'h00;
   logic        cpu_r = 1'b0;
   logic        cpu_w = 1'b0;
   wire  [7:0]  bus_i;
   wire         cpu_ce;
   wire  [15:0] A;
   wire  [7:0]  D;
   wire         R;
   wire         W;
   wire         busy;

   logic [7:0] mem [0:65535];
   assign bus_i = mem[A];

   oam_dma dut (
      .clock  (clock),
      .reset_n(reset_n),
      .ce_in  (ce_in),
      .cpu_a  (cpu_a),
      .cpu_d  (cpu_d),
      .cpu_r  (cpu_r),
      .cpu_w  (cpu_w),
      .bus_i  (bus_i),
      .cpu_ce (cpu_ce),
      .A      (A),
      .D      (D),
      .R      (R),
      .W      (W),
      .busy   (busy)
   );

   always #20 clock = ~clock;

   typedef struct {
      bit          wr;
      logic [15:0] a;
      logic [7:0]  d;
   } exp_t;

   exp_t exp_q[$];
   int   len_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   busy_cnt = 0;
   int   rd_seen = 0;
   int   ce_div = 1;
   int   ce_phase = 0;
   logic [7:0] cur_page = 8'h00;
   logic par_m = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Parity reference: counts enabled edges since reset.
   always @(posedge clock) begin
      if (!reset_n) par_m <= 1'b0;
      else if (ce_in) par_m <= ~par_m;
   end

   always @(negedge clock) begin : mon
      exp_t e;
      if (!reset_n) begin
         exp_q.delete();
         len_q.delete();
         busy_cnt = 0;
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_cpu_ce", {31'd0, cpu_ce}, {31'd0, ce_in});
         chk("rst_A", {16'd0, A}, {16'd0, cpu_a});
      end else if (busy) begin
         chk("busy_cpu_ce", {31'd0, cpu_ce}, 32'd0);
         if (ce_in) begin
            busy_cnt++;
            if (R && W) begin
               chk("both_strobes", 32'd1, 32'd0);
            end else if (R || W) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_cycle", {16'd0, A}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("cycle_kind_W", {31'd0, W}, {31'd0, e.wr});
                  chk("cycle_A", {16'd0, A}, {16'd0, e.a});
                  if (e.wr) chk("wr_D", {24'd0, D}, {24'd0, e.d});
                  if (R) rd_seen++;
               end
            end else begin
               chk("halt_A", {16'd0, A}, {16'd0, cur_page, 8'h00});
            end
         end
      end else begin
         chk("pass_A", {16'd0, A}, {16'd0, cpu_a});
         chk("pass_D", {24'd0, D}, {24'd0, cpu_d});
         chk("pass_RW", {30'd0, R, W}, {30'd0, cpu_r, cpu_w});
         chk("idle_cpu_ce", {31'd0, cpu_ce}, {31'd0, ce_in});
         if (busy_cnt > 0) begin
            if (len_q.size() == 0) chk("unexpected_busy_len", busy_cnt, 32'd0);
            else chk("busy_len", busy_cnt, len_q.pop_front());
            busy_cnt = 0;
         end
      end
   end

   task automatic tick(output bit was_ce);
      ce_in = (ce_phase == 0);
      ce_phase = (ce_phase + 1) % ce_div;
      was_ce = ce_in;
      @(posedge clock);
      #1;
   endtask

   task automatic set_div(input int d);
      ce_div = d;
      ce_phase = 0;
   endtask

   task automatic idle(input int n);
      bit c;
      for (int i = 0; i < n; i++) begin
         cpu_a = 16'($urandom);
         if (cpu_a == 16'h4014) cpu_a = 16'h4013;
         cpu_d = 8'($urandom);
         cpu_r = 1'($urandom);
         cpu_w = 1'($urandom);
         tick(c);
      end
      cpu_r = 1'b0;
      cpu_w = 1'b0;
   endtask

   task automatic fill_page(input logic [7:0] pg, input bit lowbyte);
      for (int i = 0; i < 256; i++)
         mem[{pg, 8'(i)}] = lowbyte ? 8'(i) : 8'($urandom);
   endtask

   task automatic trigger(input logic [7:0] pg);
      bit c;
      bit p;
      int n;
      exp_t e;
      n = 0;
      cpu_a = 16'h4014;
      cpu_d = pg;
      cpu_r = 1'b0;
      cpu_w = 1'b1;
      do begin
         p = par_m;
         tick(c);
         n++;
      end while (!c && n < 16);
      cpu_w = 1'b0;
      cpu_a = 16'h1234;
      for (int i = 0; i < 256; i++) begin
         e.wr = 1'b0; e.a = {pg, 8'(i)}; e.d = 8'h00;
         exp_q.push_back(e);
         e.wr = 1'b1; e.a = 16'h2004; e.d = mem[{pg, 8'(i)}];
         exp_q.push_back(e);
      end
      len_q.push_back(513 + ((ALIGN_EN && p) ? 1 : 0));
      cur_page = pg;
      rd_seen = 0;
      chk("trig_busy", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int limit);
      bit c;
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0 || len_q.size() != 0) && n < limit) begin
         tick(c);
         n++;
      end
      chk("dma_done_in_budget", {31'd0, (n < limit)}, 32'd1);
   endtask

   initial begin
      bit c;
      int n;
      logic [7:0] pg;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      // Reset with CPU traffic, including a $4014 write that must not trigger.
      set_div(1);
      reset_n = 1'b0;
      idle(3);
      cpu_a = 16'h4014; cpu_w = 1'b1; cpu_d = 8'h33;
      tick(c);
      cpu_w = 1'b0;
      reset_n = 1'b1;
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      // Page $02, full-rate enable.
      idle(4);
      fill_page(8'h02, 1'b0);
      trigger(8'h02);
      wait_done(2000);

      // Two more pages with differing idle gaps so both entry parities are covered.
      for (int k = 0; k < 2; k++) begin
         idle(1 + k);
         pg = 8'($urandom);
         fill_page(pg, 1'b0);
         trigger(pg);
         wait_done(2000);
      end

      // Page $FF with 1-in-4 enable, memory returns low address byte.
      set_div(4);
      idle(5);
      fill_page(8'hFF, 1'b1);
      trigger(8'hFF);
      wait_done(4000);

      // Reset mid-transfer, then restart.
      set_div(1);
      idle(2);
      fill_page(8'h5A, 1'b0);
      trigger(8'h5A);
      n = 0;
      while (rd_seen < 8'h81 && n < 1000) begin tick(c); n++; end
      chk("reach_cnt80", {31'd0, (n < 1000)}, 32'd1);
      cpu_a = 16'hBEEF;
      reset_n = 1'b0;
      tick(c);
      reset_n = 1'b1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cpu_ce", {31'd0, cpu_ce}, {31'd0, ce_in});
      chk("abort_A", {16'd0, A}, 32'h0000_BEEF);
      idle(3);
      trigger(8'h5A);
      wait_done(2000);

      // CPU strobes during busy, including $4014/$4015 writes: no retrigger.
      idle(2);
      pg = 8'($urandom);
      fill_page(pg, 1'b0);
      trigger(pg);
      for (int i = 0; i < 200; i++) begin
         cpu_a = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'h4015;
         cpu_d = 8'($urandom);
         cpu_w = 1'($urandom);
         cpu_r = 1'($urandom);
         tick(c);
      end
      cpu_w = 1'b0;
      cpu_r = 1'b0;
      cpu_a = 16'h0100;
      wait_done(2000);
      for (int i = 0; i < 4; i++) tick(c);
      chk("no_retrigger", {31'd0, busy}, 32'd0);

      // Random pages at random enable rates.
      for (int k = 0; k < 4; k++) begin
         set_div($urandom_range(1, 3));
         idle($urandom_range(0, 5));
         pg = 8'($urandom);
         fill_page(pg, 1'b0);
         trigger(pg);
         wait_done(2000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clock  input  1  system clock, 25 MHz.
REQ-002 reset_n  input  1  reset; synchronous, active-low.
REQ-003 ce_in  input  1  CPU-cycle enable tick from the clock divider.
REQ-004 cpu_a  input  16  CPU address.
REQ-005 cpu_d  input  8  CPU write data.
REQ-006 cpu_r  input  1  CPU read strobe.
REQ-007 cpu_w  input  1  CPU write strobe.
REQ-008 bus_i  input  8  read data returned by the memory/PPU bus for the address currently on A.
REQ-009 cpu_ce  output  1  gated enable to the CPU; equals ce_in AND NOT busy.
REQ-010 A  output  16  bus address.
REQ-011 D  output  8  bus write data.
REQ-012 R  output  1  bus read strobe.
REQ-013 W  output  1  bus write strobe.
REQ-014 busy  output  1  DMA owns the bus; the CPU is stalled.

Function
REQ-015 Passthrough: when busy=0, the block SHALL drive A=cpu_a, D=cpu_d, R=cpu_r, W=cpu_w combinationally.
REQ-016 Trigger: on a clock edge with ce_in=1, cpu_w=1 and cpu_a=16'h4014, the block SHALL latch page=cpu_d, set cnt=0 and enter HALT. On that same edge busy SHALL go to 1.
REQ-017 State machine: states are IDLE, HALT, ALIGN, RD and WR. State SHALL advance only on edges where ce_in=1.
REQ-018 HALT SHALL last one ce cycle. It SHALL then go to ALIGN if parity=1, otherwise to RD.
REQ-019 ALIGN SHALL last one ce cycle and then go to RD.
REQ-020 RD SHALL drive A={page,cnt}, R=1, W=0. On leaving RD, the block SHALL latch bus_i into the data register and go to WR.
REQ-021 WR SHALL drive A=16'h2004, D=data register, W=1, R=0. If cnt≠8'hFF, it SHALL increment cnt (8-bit) and go to RD. If cnt=8'hFF, it SHALL go to IDLE and drop busy.
REQ-022 In HALT and ALIGN the block SHALL drive A={page,8'h00}, R=0, W=0.
REQ-023 parity SHALL toggle on every ce_in=1 edge, in every state.
REQ-024 Latency: busy SHALL stay high for exactly 513 ce cycles when entry parity=0, and 514 when entry parity=1.
REQ-025 While busy=1, cpu_ce SHALL be 0, so CPU registers do not advance.
REQ-026 While busy=1, CPU strobes SHALL be ignored. A write to $4014 while busy SHALL NOT retrigger.
REQ-027 Page $FF SHALL read addresses $FF00-$FFFF with no wrap into page $00.
REQ-028 While ce_in=0, outputs SHALL hold their values and no state SHALL change.

Reset
REQ-029 reset_n=0 SHALL force IDLE, busy=0, parity=0, cnt=0, page=0, data=0. This SHALL override any operation in progress, on the next edge.
REQ-030 In reset, outputs SHALL follow passthrough (REQ-015) and cpu_ce SHALL equal ce_in.

Configuration
REQ-031 Macro OAM_DMA_ALIGN_EN: when defined, ALIGN behaves as in REQ-018/019.
REQ-032 When OAM_DMA_ALIGN_EN is undefined, HALT SHALL always go to RD, ALIGN SHALL be unreachable, and busy SHALL last exactly 513 ce cycles.

Verification
REQ-033 ce_in=1 every clock, parity=0, write $4014 data $02 -> 256 reads $0200-$02FF, each followed by a write to $2004 with the byte read; busy high 513 cycles.
REQ-034 Same trigger at parity=1 with OAM_DMA_ALIGN_EN -> busy high 514 cycles; first RD at the 3rd ce cycle after the trigger.
REQ-035 ce_in pulsing 1-in-4, page $FF, memory returns low address byte -> $2004 receives $00..$FF in order, with no $00xx access.
REQ-036 Reset pulse at cnt=$80 -> next edge busy=0, cpu_ce=ce_in, A=cpu_a; a later $4014 write restarts from cnt=0.
REQ-037 CPU write to $4014 held during busy, plus cpu_w at $4015 -> no retrigger; bus shows only DMA cycles; cpu_ce=0 throughout.
